// File: rtl/wb_sdrc_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller's single slave port.
// Optional feature macro: WB_ARB_TIMEOUT_EN (ack timeout with error pulse and forced release).
module wb_sdrc_arbiter #(
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int TO_CYC = 64
) (
  input  logic              wb_clk,
  input  logic              wb_resetn,

  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [dw/8-1:0]   m0_sel,
  input  logic [APP_AW-1:0] m0_addr,
  input  logic [dw-1:0]     m0_dati,
  input  logic [2:0]        m0_cti,
  output logic [dw-1:0]     m0_dato,
  output logic              m0_ack,
  output logic              m0_err,

  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [dw/8-1:0]   m1_sel,
  input  logic [APP_AW-1:0] m1_addr,
  input  logic [dw-1:0]     m1_dati,
  input  logic [2:0]        m1_cti,
  output logic [dw-1:0]     m1_dato,
  output logic              m1_ack,
  output logic              m1_err,

  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [dw/8-1:0]   wb_sel,
  output logic [APP_AW-1:0] wb_addr,
  output logic [dw-1:0]     wb_dati,
  output logic [2:0]        wb_cti,
  input  logic              wb_ack,
  input  logic [dw-1:0]     wb_dato,

  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       timeout;
  logic [1:0] req;
  logic       fwd_ack;

  assign grant = {state_q == OWN1, state_q == OWN0};

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [6:0] TO_LIMIT = 7'(TO_CYC - 1);

  logic [6:0] cnt_q, cnt_d;
  logic [1:0] err_q, err_d;
  logic [1:0] blocked_q, blocked_d;

  // A timed-out master stays blocked until it has dropped cyc, so it cannot re-win immediately.
  always_comb begin
    timeout   = (state_q != IDLE) && wb_stb && !wb_ack && (cnt_q == TO_LIMIT);
    cnt_d     = '0;
    if ((state_q != IDLE) && wb_stb && !wb_ack && !timeout) begin
      cnt_d = cnt_q + 7'd1;
    end
    err_d     = timeout ? grant : 2'b00;
    blocked_d = blocked_q & {m1_cyc, m0_cyc};
    if (timeout) begin
      blocked_d = blocked_d | grant;
    end
    req       = {m1_cyc & ~blocked_q[1], m0_cyc & ~blocked_q[0]};
  end

  always_ff @(posedge wb_clk or negedge wb_resetn) begin
    if (!wb_resetn) begin
      cnt_q     <= '0;
      err_q     <= 2'b00;
      blocked_q <= 2'b00;
    end else begin
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      blocked_q <= blocked_d;
    end
  end

  assign m0_err = err_q[0];
  assign m1_err = err_q[1];
`else
  logic [6:0] unused_to_limit;

  assign unused_to_limit = 7'(TO_CYC - 1);
  assign timeout         = 1'b0;
  assign req             = {m1_cyc, m0_cyc};
  assign m0_err          = 1'b0;
  assign m1_err          = 1'b0;
`endif

  // On a tie the master that did not own the bus last wins.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (req == 2'b11) begin
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (req[0]) begin
          state_d = OWN0;
        end else if (req[1]) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc || timeout) begin
          state_d      = IDLE;
          last_owner_d = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc || timeout) begin
          state_d      = IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    wb_cyc  = 1'b0;
    wb_stb  = 1'b0;
    wb_we   = 1'b0;
    wb_sel  = '0;
    wb_addr = '0;
    wb_dati = '0;
    wb_cti  = '0;
    case (state_q)
      OWN0: begin
        wb_cyc  = m0_cyc;
        wb_stb  = m0_stb;
        wb_we   = m0_we;
        wb_sel  = m0_sel;
        wb_addr = m0_addr;
        wb_dati = m0_dati;
        wb_cti  = m0_cti;
      end
      OWN1: begin
        wb_cyc  = m1_cyc;
        wb_stb  = m1_stb;
        wb_we   = m1_we;
        wb_sel  = m1_sel;
        wb_addr = m1_addr;
        wb_dati = m1_dati;
        wb_cti  = m1_cti;
      end
      default: ;
    endcase
  end

  // Slave acks outside an active strobe of the current owner are dropped.
  assign fwd_ack = wb_ack & wb_cyc & wb_stb;
  assign m0_ack  = fwd_ack & (state_q == OWN0);
  assign m1_ack  = fwd_ack & (state_q == OWN1);
  assign m0_dato = (state_q != IDLE) ? wb_dato : '0;
  assign m1_dato = (state_q != IDLE) ? wb_dato : '0;

endmodule
